pong_match_sequencer: RTL and testbench
=======================================

# pong_match_sequencer

Match-level controller for the Pong datapath. It sequences each rally through idle, serve, play, point pause and game over. It gates the ball/paddle update engine with a run enable and commands ball recentring. It owns both players' BCD scores, which feed the 7-segment controller. It sits between the game-tick ball datapath and the score display, clocked from the 100 MHz system clock and paced by the per-frame pulse from the vertical sync counter.

## Interface
Parameters:
- SERVE_FRAMES, 60: frame ticks spent in SERVE before the ball is released; legal range 1..255.
- PAUSE_FRAMES, 90: frame ticks spent in POINT after a score; legal range 1..255.
- WIN_SCORE, 8'h11: score that ends the match, BCD {tens, ones}; legal range 8'h01..8'h99.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (end of display).
- start  in  1  start button, level; synchronised upstream.
- miss_a  in  1  one-cycle pulse: ball left the field past paddle A, so B scores.
- miss_b  in  1  one-cycle pulse: ball left the field past paddle B, so A scores.
- ball_run  out  1  high only in PLAY; enables ball and paddle motion.
- ball_load  out  1  one-cycle pulse: recentre the ball and load serve_dir.
- serve_dir  out  1  0 = serve toward B (rightward), 1 = serve toward A.
- score_a  out  8  player A score, BCD {tens, ones}.
- score_b  out  8  player B score, BCD {tens, ones}.
- game_over  out  1  high in OVER.
- winner  out  1  0 = A, 1 = B; valid while game_over is high.
- state  out  3  current state encoding, for debug and LEDs.

## Operation
- States and encodings: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4. Encodings 5..7 are illegal and return to IDLE on the next edge.
- Reset (reset low) forces the following, immediately and from any state, including mid-rally:
  - state IDLE;
  - score_a = score_b = 8'h00;
  - ball_run, ball_load, serve_dir, game_over and winner all 0;
  - frame counter 0;
  - start history register 1, so a button held through reset does not start a match.
- Start edge: start_rise = start & ~start_q, where start_q is start registered every cycle.
- IDLE → SERVE on start_rise:
  - both scores clear to 0;
  - serve_dir = 0.
- SERVE:
  - ball_run = 0;
  - ball_load is high for exactly the first cycle in SERVE, whatever the source state;
  - → PLAY on the SERVE_FRAMES-th frame_tick counted in this state.
- PLAY:
  - ball_run = 1;
  - miss_a: score_b increments, serve_dir ← 1;
  - miss_b: score_a increments, serve_dir ← 0;
  - miss_a and miss_b in the same cycle: miss_a wins and miss_b is dropped;
  - after the increment, go to OVER if the new score equals WIN_SCORE (winner = scoring player), else go to POINT.
- POINT:
  - ball_run = 0;
  - → SERVE on the PAUSE_FRAMES-th frame_tick counted in this state.
- OVER:
  - game_over = 1; scores and winner hold;
  - start_rise → SERVE, with scores cleared, serve_dir = 0 and game_over falling.
- Frame counter:
  - 8-bit; cleared on every state transition;
  - increments on frame_tick in SERVE and POINT;
  - the transition fires when the counter equals N-1 and frame_tick is high, so exactly N ticks are counted;
  - a tick in the first cycle of a state counts.
- BCD increment:
  - ones 9 → 0 with tens +1;
  - the result saturates at 8'h99 and never produces a non-BCD nibble.
- Ignored inputs:
  - miss pulses outside PLAY;
  - start outside IDLE and OVER;
  - frame_tick in IDLE, PLAY and OVER.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Miss at edge t: at t+1 the score is updated, state is POINT or OVER, and ball_run is 0.
- start_rise at edge t: at t+1 state is SERVE and ball_load is 1; at t+2 ball_load is 0.
- SERVE entered at edge e with ticks at edges k1..kN: state is PLAY and ball_run is 1 from kN+1.
- Latency from start_rise to the first ball_run cycle is SERVE_FRAMES ticks plus 1 cycle.
- Reset deassertion is synchronised internally (two-flop release). The first state change is possible on the third rising edge after reset rises.

## Test plan
- Reset with start held high, release reset, keep start high → state stays IDLE (0). Drop start, raise it one cycle → next edge: state 1, ball_load 1 for one cycle, scores 8'h00.
- SERVE_FRAMES=3, 3 frame_ticks 10 cycles apart → state 2 and ball_run 1 on the edge after the 3rd tick, not before.
- In PLAY with score_a=8'h09, pulse miss_b → score_a = 8'h10, serve_dir 0, state 3. After PAUSE_FRAMES ticks → state 1 with a single-cycle ball_load.
- WIN_SCORE=8'h02, score_b=8'h01, pulse miss_a → state 4, game_over 1, winner 1, score_b 8'h02. Further miss pulses → no change. start rise → state 1, scores 8'h00, game_over 0.
- miss_a and miss_b together in PLAY → only score_b increments, serve_dir 1. miss_a pulsed in SERVE or POINT → scores unchanged.
- Assert reset mid-PLAY with score 8'h07/8'h05 → same cycle: state 0, ball_run 0, scores 8'h00.

Source files
------------

// File: rtl/pong_match_sequencer_if.sv
// Signal bundle between the Pong match sequencer and its surroundings:
// frame/button/miss inputs toward the sequencer, run/load/score/status back.
interface pong_match_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       miss_a;
  logic       miss_b;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  modport master (
    output frame_tick, start, miss_a, miss_b,
    input  ball_run, ball_load, serve_dir, score_a, score_b, game_over, winner, state
  );

  modport slave (
    input  frame_tick, start, miss_a, miss_b,
    output ball_run, ball_load, serve_dir, score_a, score_b, game_over, winner, state
  );
endinterface

// File: rtl/pong_match_sequencer.sv
// Match-level controller for Pong: sequences IDLE/SERVE/PLAY/POINT/OVER,
// gates the ball engine, commands recentring and keeps both BCD scores.
module pong_match_sequencer #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned PAUSE_FRAMES = 90,
  parameter logic [7:0]  WIN_SCORE    = 8'h11
) (
  input  logic                  clk,
  input  logic                  reset,
  pong_match_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v >= 8'h99)       return 8'h99;
    if (v[3:0] >= 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Assert immediately, release two edges after reset rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] score_a_q, score_a_d;
  logic [7:0] score_b_q, score_b_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       start_q;
  logic       ball_run_q, ball_load_q, game_over_q;
  logic       start_rise;
  logic [7:0] inc_a, inc_b;

  assign start_rise = bus.start & ~start_q;
  assign inc_a      = bcd_inc(score_a_q);
  assign inc_b      = bcd_inc(score_b_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d     = S_SERVE;
          score_a_d   = 8'h00;
          score_b_d   = 8'h00;
          serve_dir_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      S_PLAY: begin
        // A simultaneous miss_b is dropped in favour of miss_a.
        if (bus.miss_a) begin
          score_b_d   = inc_b;
          serve_dir_d = 1'b1;
          if (inc_b == WIN_SCORE) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d  = S_POINT;
          end
        end else if (bus.miss_b) begin
          score_a_d   = inc_a;
          serve_dir_d = 1'b0;
          if (inc_a == WIN_SCORE) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d  = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == PAUSE_LAST) state_d = S_SERVE;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      score_a_q   <= 8'h00;
      score_b_q   <= 8'h00;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      start_q     <= 1'b1;
      ball_run_q  <= 1'b0;
      ball_load_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      start_q     <= bus.start;
      ball_run_q  <= (state_d == S_PLAY);
      ball_load_q <= (state_d == S_SERVE) && (state_q != S_SERVE);
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign bus.state     = state_q;
  assign bus.score_a   = score_a_q;
  assign bus.score_b   = score_b_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.winner    = winner_q;
  assign bus.ball_run  = ball_run_q;
  assign bus.ball_load = ball_load_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer: a bench-side match model pushes
// expected outputs to a queue as stimulus is driven; each DUT response pops one.
module tb_pong_match_sequencer;
  localparam int         SF  = 3;
  localparam int         PF  = 2;
  localparam logic [7:0] WIN = 8'h11;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pong_match_sequencer_if bus();

  pong_match_sequencer #(
    .SERVE_FRAMES(SF),
    .PAUSE_FRAMES(PF),
    .WIN_SCORE   (WIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] sa;
    logic [7:0] sb;
    logic       dir;
    logic       run;
    logic       load;
    logic       go;
    logic       win;
  } exp_t;

  exp_t exp_q[$];

  logic [2:0] m_st;
  logic [7:0] m_a, m_b;
  logic       m_dir, m_load, m_win;

  function automatic logic [7:0] bcd_next(input logic [7:0] v);
    int n;
    n = int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
    if (n > 99) n = 99;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.st   = m_st;
    e.sa   = m_a;
    e.sb   = m_b;
    e.dir  = m_dir;
    e.run  = (m_st == 3'd2);
    e.load = m_load;
    e.go   = (m_st == 3'd4);
    e.win  = m_win;
    exp_q.push_back(e);
    m_load = 1'b0;
  endtask

  task automatic pop_chk();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".state"},     {5'd0, bus.state},     {5'd0, e.st});
    chk({e.tag, ".score_a"},   bus.score_a,           e.sa);
    chk({e.tag, ".score_b"},   bus.score_b,           e.sb);
    chk({e.tag, ".serve_dir"}, {7'd0, bus.serve_dir}, {7'd0, e.dir});
    chk({e.tag, ".ball_run"},  {7'd0, bus.ball_run},  {7'd0, e.run});
    chk({e.tag, ".ball_load"}, {7'd0, bus.ball_load}, {7'd0, e.load});
    chk({e.tag, ".game_over"}, {7'd0, bus.game_over}, {7'd0, e.go});
    if (e.go) chk({e.tag, ".winner"}, {7'd0, bus.winner}, {7'd0, e.win});
  endtask

  task automatic enter_serve();
    m_st   = 3'd1;
    m_load = 1'b1;
  endtask

  task automatic rally(input logic ma, input logic mb, input string tag);
    bus.miss_a = ma;
    bus.miss_b = mb;
    if (m_st == 3'd2) begin
      if (ma) begin
        m_b   = bcd_next(m_b);
        m_dir = 1'b1;
        if (m_b == WIN) begin m_st = 3'd4; m_win = 1'b1; end
        else            m_st = 3'd3;
      end else if (mb) begin
        m_a   = bcd_next(m_a);
        m_dir = 1'b0;
        if (m_a == WIN) begin m_st = 3'd4; m_win = 1'b0; end
        else            m_st = 3'd3;
      end
    end
    push_exp(tag);
    cycle();
    bus.miss_a = 1'b0;
    bus.miss_b = 1'b0;
    pop_chk();
  endtask

  task automatic run_frames(input int n, input logic [2:0] nxt, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) cycle();
      bus.frame_tick = 1'b1;
      if (i == n - 1) begin
        if (nxt == 3'd1) enter_serve();
        else             m_st = nxt;
      end
      push_exp($sformatf("tick%0d_to%0d", i, nxt));
      cycle();
      bus.frame_tick = 1'b0;
      pop_chk();
      if (i == n - 1 && nxt == 3'd1) begin
        push_exp("load_drop");
        cycle();
        pop_chk();
      end
    end
  endtask

  task automatic point_to_play();
    run_frames(PF, 3'd1, 2);
    run_frames(SF, 3'd2, 2);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.frame_tick = 1'b0;
    bus.miss_a     = 1'b0;
    bus.miss_b     = 1'b0;
    m_st = 3'd0; m_a = 8'h00; m_b = 8'h00;
    m_dir = 1'b0; m_load = 1'b0; m_win = 1'b0;

    #2 reset = 1'b0;
    cycle();
    cycle();
    push_exp("reset");
    pop_chk();

    // Button held through reset must not start a match.
    reset = 1'b1;
    repeat (6) cycle();
    push_exp("start_held");
    pop_chk();

    bus.start = 1'b0;
    cycle();
    bus.start = 1'b1;
    enter_serve();
    push_exp("start_rise");
    cycle();
    pop_chk();
    push_exp("load_drop0");
    cycle();
    pop_chk();
    bus.start = 1'b0;

    run_frames(SF, 3'd2, 9);

    // First point, with misses pulsed in POINT and SERVE that must be ignored.
    rally(1'b0, 1'b1, "a_pt1");
    rally(1'b1, 1'b0, "miss_in_point");
    run_frames(PF, 3'd1, 2);
    rally(1'b1, 1'b0, "miss_in_serve");
    run_frames(SF, 3'd2, 2);

    for (int i = 1; i < 9; i++) begin
      rally(1'b0, 1'b1, $sformatf("a_pt%0d", i + 1));
      point_to_play();
    end

    rally(1'b0, 1'b1, "a_bcd_carry");
    point_to_play();

    rally(1'b1, 1'b1, "both_miss");
    point_to_play();

    for (int i = 0; i < 10; i++) begin
      rally(1'b1, 1'b0, $sformatf("b_pt%0d", i + 2));
      if (m_st == 3'd3) point_to_play();
    end

    rally(1'b1, 1'b0, "over_miss_a");
    rally(1'b0, 1'b1, "over_miss_b");
    bus.frame_tick = 1'b1;
    push_exp("over_tick");
    cycle();
    bus.frame_tick = 1'b0;
    pop_chk();

    bus.start = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_dir = 1'b0;
    enter_serve();
    push_exp("restart");
    cycle();
    pop_chk();
    push_exp("restart_load_drop");
    cycle();
    pop_chk();
    bus.start = 1'b0;
    run_frames(SF, 3'd2, 2);

    for (int i = 0; i < 12; i++) begin
      rally((i < 7) ? 1'b0 : 1'b1, (i < 7) ? 1'b1 : 1'b0, $sformatf("build%0d", i));
      point_to_play();
    end

    // Reset mid-rally takes effect without waiting for a clock edge.
    reset = 1'b0;
    m_st = 3'd0; m_a = 8'h00; m_b = 8'h00;
    m_dir = 1'b0; m_load = 1'b0; m_win = 1'b0;
    push_exp("midplay_reset");
    #1;
    pop_chk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
